mod_exp_ctrl: RTL

Modular-exponentiation sequencer that computes result = base^exponent mod modulus by driving an external Montgomery multiplier (GO / is_ready handshake, 64-bit operands, 66-bit product). It converts operands into the Montgomery domain, runs a constant-time square-and-multiply over every exponent bit, converts back, and reduces each product. It sits between the lockNET crypto register interface and the Montgomery multiplier, acting as the multiplier's initiator.

---
 rtl/mod_exp_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: computes base^exponent mod modulus by sequencing an external
// Montgomery multiplier (R = 2^64) through domain entry, a constant-time
// square-and-multiply ladder over every exponent bit, and domain exit.
module mod_exp_ctrl #(
    parameter int unsigned EXP_W = 64
) (
    input  logic             pclk,
    input  logic             nreset,
    input  logic             start,
    input  logic [63:0]      base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [63:0]      modulus,
    input  logic [63:0]      r2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [63:0]      result,
    output logic             mm_go,
    output logic [63:0]      mm_a,
    output logic [63:0]      mm_b,
    output logic [63:0]      mm_m,
    input  logic [65:0]      mm_p,
    input  logic             mm_ready
);

    localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [63:0] One  = 64'd1;

    typedef enum logic [2:0] {
        StIdle,
        StConvOne,
        StConvX,
        StSqr,
        StMul,
        StConvOut,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [63:0]      mod_q, mod_d;
    logic [63:0]      r2_q, r2_d;
    logic [63:0]      base_q, base_d;
    logic [63:0]      acc_q, acc_d;
    logic [63:0]      xm_q, xm_d;
    logic [63:0]      result_q, result_d;
    logic [63:0]      mm_a_q, mm_a_d;
    logic [63:0]      mm_b_q, mm_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mm_go_q, mm_go_d;
    logic [65:0]      diff;
    logic [63:0]      corr;

    // Single conditional subtract: the product is always below 2M.
    always_comb begin
        diff = mm_p - {2'b00, mod_q};
        corr = (mm_p >= {2'b00, mod_q}) ? diff[63:0] : mm_p[63:0];
    end

    // Sequencer next-state: operand latch, arm/wait phases, product capture.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        r2_d     = r2_q;
        base_d   = base_q;
        acc_d    = acc_q;
        xm_d     = xm_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    exp_d   = exponent;
                    mod_d   = modulus;
                    r2_d    = r2;
                    base_d  = base;
                    err_d   = 1'b0;
                    phase_d = 1'b0;
                    if (!modulus[0] || (base >= modulus)) begin
                        state_d  = StFinish;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = StConvOne;
                        idx_d   = IdxW'(EXP_W - 1);
                    end
                end
            end
            StFinish: state_d = StIdle;
            StConvOne, StConvX, StSqr, StMul, StConvOut: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (mm_ready) begin
                    phase_d = 1'b0;
                    case (state_q)
                        StConvOne: begin
                            acc_d   = corr;
                            state_d = StConvX;
                        end
                        StConvX: begin
                            xm_d    = corr;
                            state_d = StSqr;
                        end
                        StSqr: begin
                            acc_d   = corr;
                            state_d = StMul;
                        end
                        StMul: begin
                            // Multiply always runs; only the write-back depends on the bit.
                            if (exp_q[idx_q]) acc_d = corr;
                            if (idx_q == '0) begin
                                state_d = StConvOut;
                            end else begin
                                idx_d   = idx_q - IdxW'(1);
                                state_d = StSqr;
                            end
                        end
                        default: begin
                            result_d = corr;
                            state_d  = StFinish;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_comb begin
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StFinish);
        mm_go_d = phase_d && (state_d != StIdle) && (state_d != StFinish);
        mm_a_d  = mm_a_q;
        mm_b_d  = mm_b_q;
        case (state_d)
            StConvOne: begin
                mm_a_d = r2_d;
                mm_b_d = One;
            end
            StConvX: begin
                mm_a_d = base_d;
                mm_b_d = r2_d;
            end
            StSqr: begin
                mm_a_d = acc_d;
                mm_b_d = acc_d;
            end
            StMul: begin
                mm_a_d = acc_d;
                mm_b_d = xm_d;
            end
            StConvOut: begin
                mm_a_d = acc_d;
                mm_b_d = One;
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any run and drops mm_go at once.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= StIdle;
            phase_q  <= 1'b0;
            idx_q    <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r2_q     <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            xm_q     <= '0;
            result_q <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mm_go_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            r2_q     <= r2_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            xm_q     <= xm_d;
            result_q <= result_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mm_go_q  <= mm_go_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign mm_go  = mm_go_q;
    assign mm_a   = mm_a_q;
    assign mm_b   = mm_b_q;
    assign mm_m   = mod_q;

endmodule
